// File: rtl/alu_divider_if.sv
// Handshake and result bundle between the ALU controller (master) and the
// multi-cycle divider (slave).
interface alu_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             N;
    logic             Z;
    logic             V;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, N, Z, V
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, N, Z, V
    );
endinterface

// File: rtl/alu_divider.sv
// Restoring divider, one quotient bit per clock, with adder-compatible N/Z/V flags.
// Define ALU_DIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module alu_divider #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    alu_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             ovf;

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             n_reg;
    logic             z_reg;
    logic             v_reg;

    logic             accept;
    logic             div_zero;
    logic             last_step;
    logic             a_neg;
    logic             b_neg;
    logic             min_ovf;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   sh_rem;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] next_quo;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

    // Operand conditioning at the accepting edge: the core always divides magnitudes.
    always_comb begin
        div_zero = (bus.B == ZERO);
        accept   = bus.start && (state != RUN);
`ifdef ALU_DIV_SIGNED_EN
        a_neg    = bus.A[WIDTH-1];
        b_neg    = bus.B[WIDTH-1];
        mag_a    = a_neg ? (ZERO - bus.A) : bus.A;
        mag_b    = b_neg ? (ZERO - bus.B) : bus.B;
        min_ovf  = (bus.A == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.B == {WIDTH{1'b1}});
`else
        a_neg    = 1'b0;
        b_neg    = 1'b0;
        mag_a    = bus.A;
        mag_b    = bus.B;
        min_ovf  = 1'b0;
`endif
    end

    // One restoring step; the extra trial bit is the borrow that rejects the subtraction.
    always_comb begin
        sh_rem    = {rem, quo[WIDTH-1]};
        trial     = sh_rem - {1'b0, dsr};
        next_quo  = {quo[WIDTH-2:0], ~trial[WIDTH]};
        next_rem  = trial[WIDTH] ? sh_rem[WIDTH-1:0] : trial[WIDTH-1:0];
        fin_q     = neg_q ? (ZERO - next_quo) : next_quo;
        fin_r     = neg_r ? (ZERO - next_rem) : next_rem;
        last_step = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DONE re-accepts start exactly like IDLE so back-to-back operations lose no cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = div_zero ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            ovf   <= 1'b0;
            q_reg <= '0;
            r_reg <= '0;
            n_reg <= 1'b0;
            z_reg <= 1'b0;
            v_reg <= 1'b0;
        end else if (accept) begin
            if (div_zero) begin
                q_reg <= {WIDTH{1'b1}};
                r_reg <= bus.A;
                n_reg <= 1'b1;
                z_reg <= 1'b0;
                v_reg <= 1'b1;
            end else begin
                quo   <= mag_a;
                dsr   <= mag_b;
                rem   <= '0;
                cnt   <= '0;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                ovf   <= min_ovf;
            end
        end else if (state == RUN) begin
            quo <= next_quo;
            rem <= next_rem;
            cnt <= cnt + CW'(1);
            // Sign fix-up rides on the final step so it costs no extra cycle.
            if (last_step) begin
                q_reg <= fin_q;
                r_reg <= fin_r;
                n_reg <= fin_q[WIDTH-1];
                z_reg <= (fin_q == ZERO);
                v_reg <= ovf;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.Q    = q_reg;
    assign bus.R    = r_reg;
    assign bus.N    = n_reg;
    assign bus.Z    = z_reg;
    assign bus.V    = v_reg;

endmodule

// File: tb/tb_alu_divider.sv
// Directed self-checking bench for alu_divider (WIDTH=4); values are hand-computed.
module tb_alu_divider;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_divider_if #(.WIDTH(WIDTH)) dif ();

    alu_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
        dif.A     = a;
        dif.B     = b;
        dif.start = s;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH-1:0] eq,
                               input logic [WIDTH-1:0] er, input logic en,
                               input logic ez, input logic ev);
        checkOutput({tag, "_done"}, 8'(dif.done), 8'd1);
        checkOutput({tag, "_busy_lo"}, 8'(dif.busy), 8'd0);
        checkOutput({tag, "_Q"}, 8'(dif.Q), 8'(eq));
        checkOutput({tag, "_R"}, 8'(dif.R), 8'(er));
        checkOutput({tag, "_N"}, 8'(dif.N), 8'(en));
        checkOutput({tag, "_Z"}, 8'(dif.Z), 8'(ez));
        checkOutput({tag, "_V"}, 8'(dif.V), 8'(ev));
    endtask

    // Called just after a falling edge with the unit idle.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                         input logic en, input logic ez, input logic ev);
        applyStimulus(a, b, 1'b1);
        @(negedge clk);
        applyStimulus(a, b, 1'b0);
        checkOutput({tag, "_busy_first"}, 8'(dif.busy), 8'd1);
        checkOutput({tag, "_done_early"}, 8'(dif.done), 8'd0);
        repeat (WIDTH - 1) @(negedge clk);
        checkOutput({tag, "_busy_last"}, 8'(dif.busy), 8'd1);
        @(negedge clk);
        checkResult(tag, eq, er, en, ez, ev);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 8'(dif.done), 8'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus('0, '0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 8'(dif.busy), 8'd0);
        checkOutput("rst_done", 8'(dif.done), 8'd0);
        checkOutput("rst_Q", 8'(dif.Q), 8'd0);
        checkOutput("rst_R", 8'(dif.R), 8'd0);
        checkOutput("rst_NZV", 8'({dif.N, dif.Z, dif.V}), 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef ALU_DIV_SIGNED_EN
        runOp("s_m7_2", 4'h9, 4'h2, 4'hD, 4'hF, 1'b1, 1'b0, 1'b0);
        runOp("s_m8_m1", 4'h8, 4'hF, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1);
        runOp("s_6_m3", 4'h6, 4'hD, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0);
`else
        runOp("u_13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0, 1'b0);
        runOp("u_2_5", 4'd2, 4'd5, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0);
`endif

        // Divide by zero finishes on the accepting edge with busy never raised.
        applyStimulus(4'd7, 4'd0, 1'b1);
        @(negedge clk);
        applyStimulus(4'd7, 4'd0, 1'b0);
        checkResult("dz_7_0", 4'hF, 4'd7, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("dz_done_pulse", 8'(dif.done), 8'd0);
        checkOutput("dz_busy_never", 8'(dif.busy), 8'd0);

`ifndef ALU_DIV_SIGNED_EN
        // A start during RUN is dropped; a start held in DONE chains the next operation.
        applyStimulus(4'd13, 4'd3, 1'b1);
        @(negedge clk);
        applyStimulus(4'd9, 4'd2, 1'b1);
        repeat (2) @(negedge clk);
        applyStimulus(4'd9, 4'd2, 1'b0);
        checkOutput("ign_busy", 8'(dif.busy), 8'd1);
        repeat (2) @(negedge clk);
        checkResult("ign_13_3", 4'd4, 4'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'd9, 4'd2, 1'b1);
        @(negedge clk);
        applyStimulus(4'd9, 4'd2, 1'b0);
        checkOutput("b2b_busy", 8'(dif.busy), 8'd1);
        checkOutput("b2b_done_lo", 8'(dif.done), 8'd0);
        repeat (WIDTH - 1) @(negedge clk);
        checkOutput("b2b_busy_last", 8'(dif.busy), 8'd1);
        @(negedge clk);
        checkResult("b2b_9_2", 4'd4, 4'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
`endif

        // Reset in the middle of RUN clears everything immediately.
        applyStimulus(4'd13, 4'd3, 1'b1);
        @(negedge clk);
        applyStimulus(4'd13, 4'd3, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 8'(dif.busy), 8'd0);
        checkOutput("mid_rst_done", 8'(dif.done), 8'd0);
        checkOutput("mid_rst_Q", 8'(dif.Q), 8'd0);
        checkOutput("mid_rst_R", 8'(dif.R), 8'd0);
        checkOutput("mid_rst_NZV", 8'({dif.N, dif.Z, dif.V}), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp("post_rst_15_15", 4'hF, 4'hF, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
